// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage divider: op_i bit layout, op codes,
// the M-extension funct3 values and operand-preparation helpers.
package ex_div_pkg;

   localparam int OP_UNS_BIT  = 0;
   localparam int OP_REM_BIT  = 1;
   localparam int OP_WORD_BIT = 2;

   localparam logic [2:0] OP_DIV   = 3'b000;
   localparam logic [2:0] OP_DIVU  = 3'b001;
   localparam logic [2:0] OP_REM   = 3'b010;
   localparam logic [2:0] OP_REMU  = 3'b011;
   localparam logic [2:0] OP_DIVW  = 3'b100;
   localparam logic [2:0] OP_DIVUW = 3'b101;
   localparam logic [2:0] OP_REMW  = 3'b110;
   localparam logic [2:0] OP_REMUW = 3'b111;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   function automatic logic [63:0] sext_word(input logic [31:0] w);
      return {{32{w[31]}}, w};
   endfunction

   // Word ops look only at the low half; signedness picks the extension.
   function automatic logic [63:0] prep_operand(input logic [63:0] v,
                                                input logic word,
                                                input logic uns);
      if (!word)
         return v;
      else if (uns)
         return {32'd0, v[31:0]};
      else
         return sext_word(v[31:0]);
   endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring radix-2 divider for RV64 DIV/REM (and W variants),
// one quotient bit per cycle, with optional early-out for /0 and overflow.
module ex_div
   import ex_div_pkg::*;
#(
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [63:0] dividend_i,
   input  logic [63:0] divisor_i,
   input  logic [2:0]  op_i,
   input  logic [4:0]  rd_addr_i,
   output logic        busy_o,
   output logic        stall_flag_o,
   output logic        valid_o,
   output logic [63:0] result_o,
   output logic [4:0]  rd_addr_o,
   output logic        reg_wen_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r, next_state_s;
   logic [6:0]  cnt_r;
   logic [63:0] dvd_r, dsr_r, rem_r;
   logic        word_r, rem_op_r, neg_q_r, neg_r_r;
   logic [4:0]  rd_r;

   logic        word_s, uns_s, a_neg_s, b_neg_s, div0_s, ovf_s, early_s, accept_s, last_s;
   logic [63:0] a_s, b_s, a_mag_s, b_mag_s, min_s;
   logic [64:0] tmp_s, diff_s;
   logic [63:0] q_fix_s, r_fix_s, sel_s, fixed_s;

   // Operand preparation and special-case detection on the request.
   always_comb begin
      word_s   = op_i[OP_WORD_BIT];
      uns_s    = op_i[OP_UNS_BIT];
      a_s      = prep_operand(dividend_i, word_s, uns_s);
      b_s      = prep_operand(divisor_i, word_s, uns_s);
      a_neg_s  = ~uns_s & a_s[63];
      b_neg_s  = ~uns_s & b_s[63];
      a_mag_s  = a_neg_s ? (64'd0 - a_s) : a_s;
      b_mag_s  = b_neg_s ? (64'd0 - b_s) : b_s;
      min_s    = word_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      div0_s   = (b_s == 64'd0);
      ovf_s    = ~uns_s & (a_s == min_s) & (b_s == 64'hFFFF_FFFF_FFFF_FFFF);
      early_s  = EARLY_OUT & (div0_s | ovf_s);
      accept_s = (state_r == IDLE) & start_i & ~flush_i;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      tmp_s  = {rem_r, dvd_r[63]};
      diff_s = tmp_s - {1'b0, dsr_r};
      last_s = (cnt_r == (word_r ? 7'd31 : 7'd63));
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_r <= IDLE;
      else
         state_r <= next_state_s;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    begin
                     if (accept_s)
                        next_state_s = early_s ? DONE : CALC;
                     else
                        next_state_s = IDLE;
                  end
         CALC:    next_state_s = last_s ? DONE : CALC;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
      if (flush_i)
         next_state_s = IDLE;
      else
         next_state_s = next_state_s;
   end

   // Operand capture on accept and the per-cycle iteration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r    <= 7'd0;
         dvd_r    <= 64'd0;
         dsr_r    <= 64'd0;
         rem_r    <= 64'd0;
         word_r   <= 1'b0;
         rem_op_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         rd_r     <= 5'd0;
      end else if (accept_s) begin
         cnt_r    <= 7'd0;
         word_r   <= word_s;
         rem_op_r <= op_i[OP_REM_BIT];
         rd_r     <= rd_addr_i;
         dsr_r    <= b_mag_s;
         if (early_s) begin
            // Final values loaded directly; no sign fix-up applies.
            dvd_r   <= div0_s ? 64'hFFFF_FFFF_FFFF_FFFF : a_s;
            rem_r   <= div0_s ? a_s : 64'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
         end else begin
            // Word magnitudes are pre-shifted so 32 steps consume them.
            dvd_r   <= word_s ? {a_mag_s[31:0], 32'd0} : a_mag_s;
            rem_r   <= 64'd0;
            neg_q_r <= (a_neg_s ^ b_neg_s) & ~div0_s;
            neg_r_r <= a_neg_s;
         end
      end else if (state_r == CALC) begin
         cnt_r <= cnt_r + 7'd1;
         dvd_r <= {dvd_r[62:0], ~diff_s[64]};
         rem_r <= diff_s[64] ? tmp_s[63:0] : diff_s[63:0];
      end
   end

   // Sign fix-up and word sign-extension of the selected result.
   always_comb begin
      q_fix_s = neg_q_r ? (64'd0 - dvd_r) : dvd_r;
      r_fix_s = neg_r_r ? (64'd0 - rem_r) : rem_r;
      sel_s   = rem_op_r ? r_fix_s : q_fix_s;
      fixed_s = word_r ? sext_word(sel_s[31:0]) : sel_s;
   end

   // Outputs decoded from state.
   always_comb begin
      busy_o       = (state_r != IDLE);
      stall_flag_o = rst & ((start_i & (state_r == IDLE)) | (state_r == CALC));
      valid_o      = (state_r == DONE) & ~flush_i;
      reg_wen_o    = (state_r == DONE) & ~flush_i;
      if (state_r == DONE)
         result_o = fixed_s;
      else
         result_o = 64'd0;
      rd_addr_o    = rd_r;
   end

endmodule
